// File: rtl/liang_pkg.sv
// Shared widths, response codes and arbiter state encoding for the fetch/LSU memory path.
package liang_pkg;

  localparam int ADDR_WIDTH = 32;
  localparam int DATA_WIDTH = 32;

  typedef logic [1:0] axi_resp_t;
  localparam axi_resp_t RESP_OKAY   = 2'b00;
  localparam axi_resp_t RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RD_IFU = 2'd1,
    RD_LSU = 2'd2,
    WR_LSU = 2'd3
  } arb_state_t;

endpackage

// File: rtl/axi_lite_arbiter.sv
// Fixed-priority (LSU write > LSU read > fetch) single-outstanding AXI-Lite arbiter; 1-cycle grant, 0-cycle response path.
// Backpressure passes straight through: the grant is held until the owner's final response handshake, never preempted.
module axi_lite_arbiter #(
  parameter int ADDR_WIDTH = liang_pkg::ADDR_WIDTH,
  parameter int DATA_WIDTH = liang_pkg::DATA_WIDTH
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  // fetch read master
  input  logic [ADDR_WIDTH-1:0]   ifu_araddr_i,
  input  logic                    ifu_arvalid_i,
  output logic                    ifu_arready_o,
  output logic [DATA_WIDTH-1:0]   ifu_rdata_o,
  output logic                    ifu_rvalid_o,
  input  logic                    ifu_rready_i,
  // load/store master
  input  logic [ADDR_WIDTH-1:0]   lsu_araddr_i,
  input  logic                    lsu_arvalid_i,
  output logic                    lsu_arready_o,
  output logic [DATA_WIDTH-1:0]   lsu_rdata_o,
  output logic [1:0]              lsu_rresp_o,
  output logic                    lsu_rvalid_o,
  input  logic                    lsu_rready_i,
  input  logic [ADDR_WIDTH-1:0]   lsu_awaddr_i,
  input  logic                    lsu_awvalid_i,
  output logic                    lsu_awready_o,
  input  logic [DATA_WIDTH-1:0]   lsu_wdata_i,
  input  logic [DATA_WIDTH/8-1:0] lsu_wstrb_i,
  input  logic                    lsu_wvalid_i,
  output logic                    lsu_wready_o,
  output logic [1:0]              lsu_bresp_o,
  output logic                    lsu_bvalid_o,
  input  logic                    lsu_bready_i,
  // slave port
  output logic [ADDR_WIDTH-1:0]   m_araddr_o,
  output logic                    m_arvalid_o,
  input  logic                    m_arready_i,
  input  logic [DATA_WIDTH-1:0]   m_rdata_i,
  input  logic [1:0]              m_rresp_i,
  input  logic                    m_rvalid_i,
  output logic                    m_rready_o,
  output logic [ADDR_WIDTH-1:0]   m_awaddr_o,
  output logic                    m_awvalid_o,
  input  logic                    m_awready_i,
  output logic [DATA_WIDTH-1:0]   m_wdata_o,
  output logic [DATA_WIDTH/8-1:0] m_wstrb_o,
  output logic                    m_wvalid_o,
  input  logic                    m_wready_i,
  input  logic [1:0]              m_bresp_i,
  input  logic                    m_bvalid_i,
  output logic                    m_bready_o
);
  import liang_pkg::*;

  arb_state_t state;
  logic       ar_done;
  logic       aw_done;
  logic       w_done;

  logic owner_ifu;
  logic rd_active;
  logic wr_active;
  logic ar_open;
  logic r_open;
  logic b_open;
  logic owner_arvalid;
  logic owner_rready;

  assign owner_ifu = (state == RD_IFU);
  assign rd_active = (state == RD_IFU) || (state == RD_LSU);
  assign wr_active = (state == WR_LSU);
  assign ar_open   = rd_active && !ar_done;
  // R is only opened after AR completes so a response racing the address handshake is never consumed early.
  assign r_open    = rd_active && ar_done;
  assign b_open    = wr_active && aw_done && w_done;

  // Shared read-path mux, steered by the current read owner.
  assign owner_arvalid = owner_ifu ? ifu_arvalid_i : lsu_arvalid_i;
  assign owner_rready  = owner_ifu ? ifu_rready_i  : lsu_rready_i;

  assign m_araddr_o  = owner_ifu ? ifu_araddr_i : lsu_araddr_i;
  assign m_arvalid_o = ar_open && owner_arvalid;
  assign m_rready_o  = r_open && owner_rready;

  assign ifu_arready_o = ar_open && owner_ifu && m_arready_i;
  assign lsu_arready_o = ar_open && !owner_ifu && m_arready_i;
  assign ifu_rvalid_o  = r_open && owner_ifu && m_rvalid_i;
  assign lsu_rvalid_o  = r_open && !owner_ifu && m_rvalid_i;
  assign ifu_rdata_o   = m_rdata_i;
  assign lsu_rdata_o   = m_rdata_i;
  assign lsu_rresp_o   = m_rresp_i;

  assign m_awaddr_o    = lsu_awaddr_i;
  assign m_awvalid_o   = wr_active && !aw_done && lsu_awvalid_i;
  assign lsu_awready_o = wr_active && !aw_done && m_awready_i;
  assign m_wdata_o     = lsu_wdata_i;
  assign m_wstrb_o     = lsu_wstrb_i;
  assign m_wvalid_o    = wr_active && !w_done && lsu_wvalid_i;
  assign lsu_wready_o  = wr_active && !w_done && m_wready_i;
  assign lsu_bresp_o   = m_bresp_i;
  assign lsu_bvalid_o  = b_open && m_bvalid_i;
  assign m_bready_o    = b_open && lsu_bready_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state   <= IDLE;
      ar_done <= 1'b0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          ar_done <= 1'b0;
          aw_done <= 1'b0;
          w_done  <= 1'b0;
          if (lsu_awvalid_i || lsu_wvalid_i) state <= WR_LSU;
          else if (lsu_arvalid_i)            state <= RD_LSU;
          else if (ifu_arvalid_i)            state <= RD_IFU;
        end
        RD_IFU, RD_LSU: begin
          if (m_arvalid_o && m_arready_i) ar_done <= 1'b1;
          if (m_rvalid_i && m_rready_o)   state   <= IDLE;
        end
        WR_LSU: begin
          if (m_awvalid_o && m_awready_i) aw_done <= 1'b1;
          if (m_wvalid_o && m_wready_i)   w_done  <= 1'b1;
          if (m_bvalid_i && m_bready_o)   state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_lite_arbiter.sv
// Directed-vector bench: inputs change just after each falling edge, outputs are checked 1 ns later.
module tb_axi_lite_arbiter;
  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic [31:0] ifu_araddr_i;
  logic        ifu_arvalid_i, ifu_arready_o;
  logic [31:0] ifu_rdata_o;
  logic        ifu_rvalid_o, ifu_rready_i;
  logic [31:0] lsu_araddr_i;
  logic        lsu_arvalid_i, lsu_arready_o;
  logic [31:0] lsu_rdata_o;
  logic [1:0]  lsu_rresp_o;
  logic        lsu_rvalid_o, lsu_rready_i;
  logic [31:0] lsu_awaddr_i;
  logic        lsu_awvalid_i, lsu_awready_o;
  logic [31:0] lsu_wdata_i;
  logic [3:0]  lsu_wstrb_i;
  logic        lsu_wvalid_i, lsu_wready_o;
  logic [1:0]  lsu_bresp_o;
  logic        lsu_bvalid_o, lsu_bready_i;
  logic [31:0] m_araddr_o;
  logic        m_arvalid_o, m_arready_i;
  logic [31:0] m_rdata_i;
  logic [1:0]  m_rresp_i;
  logic        m_rvalid_i, m_rready_o;
  logic [31:0] m_awaddr_o;
  logic        m_awvalid_o, m_awready_i;
  logic [31:0] m_wdata_o;
  logic [3:0]  m_wstrb_o;
  logic        m_wvalid_o, m_wready_i;
  logic [1:0]  m_bresp_i;
  logic        m_bvalid_i, m_bready_o;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk_i = ~clk_i;

  axi_lite_arbiter dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .ifu_araddr_i(ifu_araddr_i), .ifu_arvalid_i(ifu_arvalid_i), .ifu_arready_o(ifu_arready_o),
    .ifu_rdata_o(ifu_rdata_o), .ifu_rvalid_o(ifu_rvalid_o), .ifu_rready_i(ifu_rready_i),
    .lsu_araddr_i(lsu_araddr_i), .lsu_arvalid_i(lsu_arvalid_i), .lsu_arready_o(lsu_arready_o),
    .lsu_rdata_o(lsu_rdata_o), .lsu_rresp_o(lsu_rresp_o), .lsu_rvalid_o(lsu_rvalid_o),
    .lsu_rready_i(lsu_rready_i),
    .lsu_awaddr_i(lsu_awaddr_i), .lsu_awvalid_i(lsu_awvalid_i), .lsu_awready_o(lsu_awready_o),
    .lsu_wdata_i(lsu_wdata_i), .lsu_wstrb_i(lsu_wstrb_i), .lsu_wvalid_i(lsu_wvalid_i),
    .lsu_wready_o(lsu_wready_o),
    .lsu_bresp_o(lsu_bresp_o), .lsu_bvalid_o(lsu_bvalid_o), .lsu_bready_i(lsu_bready_i),
    .m_araddr_o(m_araddr_o), .m_arvalid_o(m_arvalid_o), .m_arready_i(m_arready_i),
    .m_rdata_i(m_rdata_i), .m_rresp_i(m_rresp_i), .m_rvalid_i(m_rvalid_i), .m_rready_o(m_rready_o),
    .m_awaddr_o(m_awaddr_o), .m_awvalid_o(m_awvalid_o), .m_awready_i(m_awready_i),
    .m_wdata_o(m_wdata_o), .m_wstrb_o(m_wstrb_o), .m_wvalid_o(m_wvalid_o), .m_wready_i(m_wready_i),
    .m_bresp_i(m_bresp_i), .m_bvalid_i(m_bvalid_i), .m_bready_o(m_bready_o)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Advance to the low phase of the next cycle; caller then drives inputs and calls settle().
  task automatic next_cycle();
    @(negedge clk_i);
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic clear_inputs();
    ifu_araddr_i = 32'h0; ifu_arvalid_i = 1'b0; ifu_rready_i = 1'b1;
    lsu_araddr_i = 32'h0; lsu_arvalid_i = 1'b0; lsu_rready_i = 1'b1;
    lsu_awaddr_i = 32'h0; lsu_awvalid_i = 1'b0;
    lsu_wdata_i = 32'h0; lsu_wstrb_i = 4'h0; lsu_wvalid_i = 1'b0; lsu_bready_i = 1'b1;
    m_arready_i = 1'b1; m_rdata_i = 32'h0; m_rresp_i = 2'b00; m_rvalid_i = 1'b0;
    m_awready_i = 1'b1; m_wready_i = 1'b1; m_bresp_i = 2'b00; m_bvalid_i = 1'b0;
  endtask

  initial begin
    clear_inputs();
    rst_ni = 1'b0;
    // Reset: requests pending, every handshake output must stay low.
    ifu_arvalid_i = 1'b1; lsu_arvalid_i = 1'b1; lsu_wvalid_i = 1'b1; m_rvalid_i = 1'b1; m_bvalid_i = 1'b1;
    next_cycle(); settle();
    chk("rst_m_arvalid", 32'(m_arvalid_o), 32'h0);
    chk("rst_m_wvalid",  32'(m_wvalid_o),  32'h0);
    chk("rst_lsu_rvalid", 32'(lsu_rvalid_o), 32'h0);
    chk("rst_lsu_bvalid", 32'(lsu_bvalid_o), 32'h0);
    chk("rst_m_rready",  32'(m_rready_o),  32'h0);
    next_cycle();
    clear_inputs();
    rst_ni = 1'b1;

    // Single fetch, 0-wait slave.
    next_cycle();
    ifu_arvalid_i = 1'b1; ifu_araddr_i = 32'h8000_0000; settle();
    chk("f_c0_arvalid", 32'(m_arvalid_o), 32'h0);
    next_cycle(); settle();
    chk("f_c1_arvalid", 32'(m_arvalid_o), 32'h1);
    chk("f_c1_araddr",  m_araddr_o, 32'h8000_0000);
    chk("f_c1_arready", 32'(ifu_arready_o), 32'h1);
    chk("f_c1_rvalid",  32'(ifu_rvalid_o), 32'h0);
    next_cycle();
    ifu_arvalid_i = 1'b0; m_rvalid_i = 1'b1; m_rdata_i = 32'h0000_0413; settle();
    chk("f_c2_rvalid",  32'(ifu_rvalid_o), 32'h1);
    chk("f_c2_rdata",   ifu_rdata_o, 32'h0000_0413);
    chk("f_c2_mrready", 32'(m_rready_o), 32'h1);
    chk("f_c2_arvalid", 32'(m_arvalid_o), 32'h0);
    next_cycle(); settle();
    chk("f_c3_idle_rvalid", 32'(ifu_rvalid_o), 32'h0);
    chk("f_c3_idle_rready", 32'(m_rready_o), 32'h0);
    clear_inputs();

    // Contention: LSU read wins, fetch follows after one idle cycle.
    next_cycle();
    ifu_arvalid_i = 1'b1; ifu_araddr_i = 32'h8000_0004;
    lsu_arvalid_i = 1'b1; lsu_araddr_i = 32'h8000_1000; settle();
    next_cycle(); settle();
    chk("c_lsu_araddr",  m_araddr_o, 32'h8000_1000);
    chk("c_lsu_arready", 32'(lsu_arready_o), 32'h1);
    chk("c_ifu_arready", 32'(ifu_arready_o), 32'h0);
    next_cycle();
    lsu_arvalid_i = 1'b0; m_rvalid_i = 1'b1; m_rdata_i = 32'h1234_5678; settle();
    chk("c_lsu_rvalid", 32'(lsu_rvalid_o), 32'h1);
    chk("c_lsu_rdata",  lsu_rdata_o, 32'h1234_5678);
    chk("c_ifu_rvalid", 32'(ifu_rvalid_o), 32'h0);
    next_cycle();
    m_rvalid_i = 1'b0; settle();
    chk("c_idle_arvalid", 32'(m_arvalid_o), 32'h0);
    next_cycle(); settle();
    chk("c_ifu_arvalid", 32'(m_arvalid_o), 32'h1);
    chk("c_ifu_araddr",  m_araddr_o, 32'h8000_0004);
    next_cycle();
    ifu_arvalid_i = 1'b0; m_rvalid_i = 1'b1; settle();
    chk("c_ifu_rvalid2", 32'(ifu_rvalid_o), 32'h1);
    next_cycle();
    clear_inputs();

    // Write with W accepted two cycles before AW.
    next_cycle();
    lsu_wvalid_i = 1'b1; lsu_wdata_i = 32'h0000_0041; lsu_wstrb_i = 4'h1; settle();
    chk("w_c0_wvalid", 32'(m_wvalid_o), 32'h0);
    next_cycle(); settle();
    chk("w_c1_wvalid", 32'(m_wvalid_o), 32'h1);
    chk("w_c1_wready", 32'(lsu_wready_o), 32'h1);
    chk("w_c1_wdata",  m_wdata_o, 32'h0000_0041);
    chk("w_c1_wstrb",  32'(m_wstrb_o), 32'h1);
    chk("w_c1_awvalid", 32'(m_awvalid_o), 32'h0);
    next_cycle();
    lsu_wvalid_i = 1'b0; m_bvalid_i = 1'b1; settle();
    chk("w_c2_wvalid", 32'(m_wvalid_o), 32'h0);
    chk("w_c2_bvalid", 32'(lsu_bvalid_o), 32'h0);
    chk("w_c2_bready", 32'(m_bready_o), 32'h0);
    next_cycle();
    lsu_awvalid_i = 1'b1; lsu_awaddr_i = 32'ha000_03f8; settle();
    chk("w_c3_awvalid", 32'(m_awvalid_o), 32'h1);
    chk("w_c3_awaddr",  m_awaddr_o, 32'ha000_03f8);
    chk("w_c3_awready", 32'(lsu_awready_o), 32'h1);
    chk("w_c3_bvalid",  32'(lsu_bvalid_o), 32'h0);
    next_cycle();
    lsu_awvalid_i = 1'b0; settle();
    chk("w_c4_bvalid", 32'(lsu_bvalid_o), 32'h1);
    chk("w_c4_bresp",  32'(lsu_bresp_o), 32'h0);
    chk("w_c4_bready", 32'(m_bready_o), 32'h1);
    chk("w_c4_awvalid", 32'(m_awvalid_o), 32'h0);
    next_cycle(); settle();
    chk("w_c5_idle_bvalid", 32'(lsu_bvalid_o), 32'h0);
    clear_inputs();

    // Fetch backpressure with a competing LSU request.
    next_cycle();
    ifu_arvalid_i = 1'b1; ifu_araddr_i = 32'h8000_0010; ifu_rready_i = 1'b0;
    next_cycle(); settle();
    chk("bp_arvalid", 32'(m_arvalid_o), 32'h1);
    next_cycle();
    ifu_arvalid_i = 1'b0; lsu_arvalid_i = 1'b1; lsu_araddr_i = 32'h8000_2000;
    m_rvalid_i = 1'b1; m_rdata_i = 32'hdead_beef;
    for (int i = 0; i < 5; i++) begin
      settle();
      chk("bp_rvalid",  32'(ifu_rvalid_o), 32'h1);
      chk("bp_rdata",   ifu_rdata_o, 32'hdead_beef);
      chk("bp_mrready", 32'(m_rready_o), 32'h0);
      chk("bp_lsu_arready", 32'(lsu_arready_o), 32'h0);
      chk("bp_m_arvalid", 32'(m_arvalid_o), 32'h0);
      next_cycle();
    end
    ifu_rready_i = 1'b1; settle();
    chk("bp_release_mrready", 32'(m_rready_o), 32'h1);
    next_cycle();
    m_rvalid_i = 1'b0; settle();
    chk("bp_idle_arvalid", 32'(m_arvalid_o), 32'h0);

    // LSU read: SLVERR forwarded combinationally, then reset mid-transaction.
    next_cycle(); settle();
    chk("rl_arvalid", 32'(m_arvalid_o), 32'h1);
    chk("rl_araddr",  m_araddr_o, 32'h8000_2000);
    next_cycle();
    lsu_arvalid_i = 1'b0; lsu_rready_i = 1'b0; m_rvalid_i = 1'b1; m_rresp_i = 2'b10; settle();
    chk("rl_rvalid", 32'(lsu_rvalid_o), 32'h1);
    chk("rl_rresp",  32'(lsu_rresp_o), 32'h2);
    rst_ni = 1'b0; settle();
    chk("rl_rst_rvalid", 32'(lsu_rvalid_o), 32'h0);
    chk("rl_rst_mrready", 32'(m_rready_o), 32'h0);
    lsu_rready_i = 1'b1; settle();
    chk("rl_rst_mrready2", 32'(m_rready_o), 32'h0);
    next_cycle();
    rst_ni = 1'b1; settle();
    chk("rl_post_rvalid", 32'(lsu_rvalid_o), 32'h0);
    chk("rl_post_arvalid", 32'(m_arvalid_o), 32'h0);
    clear_inputs();

    // Complete an LSU read carrying SLVERR and return to idle.
    next_cycle();
    lsu_arvalid_i = 1'b1; lsu_araddr_i = 32'h8000_3000;
    next_cycle();
    next_cycle();
    lsu_arvalid_i = 1'b0; m_rvalid_i = 1'b1; m_rresp_i = 2'b10; settle();
    chk("se_rvalid", 32'(lsu_rvalid_o), 32'h1);
    chk("se_rresp",  32'(lsu_rresp_o), 32'h2);
    chk("se_mrready", 32'(m_rready_o), 32'h1);
    next_cycle(); settle();
    chk("se_idle_rvalid", 32'(lsu_rvalid_o), 32'h0);
    clear_inputs();

    next_cycle();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
